// File: rtl/pipe_stage_reg.sv
// Single pipeline stage register with valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_SKID_EN to add a skid register, a FULL state and a registered in_ready.
module pipe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State encoding equals the number of held entries, so count is the state register itself.
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic             accept;
  logic             deliver;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;
  assign deliver   = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;

  assign in_ready = ready_q;

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      if (CLEAR_DATA != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_q <= in_data;
          end else if (deliver) begin
            state <= EMPTY;
          end else if (accept) begin
            skid_q  <= in_data;
            state   <= FULL;
            ready_q <= 1'b0;
          end
        end
        FULL: begin
          if (deliver) begin
            main_q  <= skid_q;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  // Without a skid slot the stage can only refill in the same cycle it drains.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (CLEAR_DATA != 0) begin
        main_q <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_q <= in_data;
          end else if (deliver) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors plus a random handshake soak.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_pipe_stage_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] data_prev  = '0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(WIDTH), .CLEAR_DATA(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sees the handshake that the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, data_prev);
      end
      stall_prev = out_valid && !out_ready && !flush;
      data_prev  = out_data;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_deliver", out_data, 32'hDEAD_BEEF);
          end else begin
            check("deliver_data", out_data, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int iters;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First transfer: 1-cycle latency
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a5_valid", 32'(out_valid), 32'd1);
    check("a5_data", out_data, 32'hA5);
    check("a5_count", 32'(count), 32'd1);
    tick();
    check("a5_drained", 32'(count), 32'd0);

    // Streaming at one payload per cycle
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", out_data, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(count), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
    check("bp_count", 32'(count), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_data", out_data, 32'h11);
    out_ready = 1'b1;
    tick();
`else
    check("bp_count", 32'(count), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_data", out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
`endif
    check("bp_second", out_data, 32'h22);
    check("bp_count1", 32'(count), 32'd1);
    tick();
    check("bp_drained", 32'(count), 32'd0);
    out_ready = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
    // Flush while FULL
    in_valid = 1'b1; in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    check("full_before_flush", 32'(count), 32'd2);
    flush = 1'b1; in_data = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_count", 32'(count), 32'd0);
    check("flush_full_data", out_data, 32'h0);
    check("flush_full_in_ready", 32'(in_ready), 32'd1);
`endif

    // Flush while ONE, with in_ready high
    in_valid = 1'b1; in_data = 32'h66;
    tick();
    flush = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    #1;
    check("flush_one_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_valid", 32'(out_valid), 32'd0);
    check("flush_one_count", 32'(count), 32'd0);
    check("flush_one_data", out_data, 32'h0);
    tick(); tick();
    check("flush_no_33", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", out_data, 32'h0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    reset_n = 1'b1;
    check("rerelease_in_ready", 32'(in_ready), 32'd1);
    check("rerelease_valid", 32'(out_valid), 32'd0);

    // Random handshake soak
    sent = 0;
    iters = 0;
    while (sent < 1000 && iters < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom();
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
      iters++;
    end
    check("soak_sent", 32'(sent), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    check("soak_queue_empty", 32'(exp_q.size()), 32'd0);
    check("soak_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
